// File: rtl/shunt_fringe_pkg.sv
`timescale 1ns/1ps
// Shared types for the shunt hub endpoint: frame layout, link kinds,
// endpoint status and the mailbox payload.
package shunt_fringe_pkg;

    localparam int N_SRCDST_DEF = 4;
    localparam int N_SIG_DEF    = 16;
    localparam int DATA_W_DEF   = 64;
    localparam int ID_W_DEF     = $clog2(N_SRCDST_DEF);
    localparam int SIG_W_DEF    = $clog2(N_SIG_DEF);

    typedef enum logic [1:0] {
        KIND_DATA      = 2'd0,
        KIND_HELLO     = 2'd1,
        KIND_HELLO_ACK = 2'd2,
        KIND_EOS       = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_INACTIVE = 2'd0,
        ST_PNP      = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_EOS      = 2'd3
    } status_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data_bit;
        logic [DATA_W_DEF-1:0] data_logic;
    } data_in_t;

    // Field order is the wire order, MSB first.
    typedef struct packed {
        kind_e                kind;
        logic [ID_W_DEF-1:0]  src;
        logic [ID_W_DEF-1:0]  dst;
        logic [SIG_W_DEF-1:0] sig;
        logic                 typ;
        data_in_t             data;
    } frame_t;

    function automatic frame_t make_frame(
        input kind_e                k,
        input logic [ID_W_DEF-1:0]  src,
        input logic [ID_W_DEF-1:0]  dst,
        input logic [SIG_W_DEF-1:0] sig,
        input logic                 typ,
        input data_in_t             data
    );
        frame_t f;
        f.kind = k;
        f.src  = src;
        f.dst  = dst;
        f.sig  = sig;
        f.typ  = typ;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/shunt_fringe_mailbox.sv
`timescale 1ns/1ps
// Per-(source, signal) mailbox: one write port fed by received frames and
// one read-and-clear port serving gets. Tracks a sticky overrun flag.
module shunt_fringe_mailbox
    import shunt_fringe_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [ID_W_DEF-1:0]  wr_src_i,
    input  logic [SIG_W_DEF-1:0] wr_sig_i,
    input  data_in_t             wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ID_W_DEF-1:0]  rd_src_i,
    input  logic [SIG_W_DEF-1:0] rd_sig_i,
    output logic                 rd_hit_o,
    output data_in_t             rd_data_o,
    output logic                 overrun_o
);

    localparam int N_ENT = N_SRCDST_DEF * N_SIG_DEF;
    localparam int IDX_W = ID_W_DEF + SIG_W_DEF;

    logic [N_ENT-1:0] valid_q, valid_d;
    logic             overrun_q, overrun_d;
    data_in_t         mem_q [N_ENT];

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             rd_clr;

    assign wr_idx    = {wr_src_i, wr_sig_i};
    assign rd_idx    = {rd_src_i, rd_sig_i};
    assign rd_hit_o  = valid_q[rd_idx];
    assign rd_data_o = mem_q[rd_idx];
    assign rd_clr    = rd_en_i && rd_hit_o;
    assign overrun_o = overrun_q;

    // Valid/overrun update: the clear is applied before the write so a same-entry write stays valid.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (rd_clr) begin
            valid_d[rd_idx] = 1'b0;
        end
        if (wr_en_i) begin
            if (valid_q[wr_idx] && !(rd_clr && (rd_idx == wr_idx))) begin
                overrun_d = 1'b1;
            end
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            valid_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Payload storage.
    always_ff @(posedge clk_i) begin
        // NOTE: payload RAM has no reset; the valid bits gate every read, so stale data is never delivered.
        if (wr_en_i) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/shunt_fringe.sv
`timescale 1ns/1ps
// Shunt hub endpoint: plug-and-play registration, free-running time,
// single-slot tx for put/HELLO/EOS frames, mailbox-backed non-blocking get.
module shunt_fringe
    import shunt_fringe_pkg::*;
#(
    parameter int N_SRCDST = N_SRCDST_DEF,
    parameter int N_SIG    = N_SIG_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ID_W     = $clog2(N_SRCDST),
    parameter int SIG_W    = $clog2(N_SIG),
    parameter int FRAME_W  = 2 + 2*ID_W + SIG_W + 1 + 2*DATA_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [ID_W-1:0]    my_id_i,
    input  logic [31:0]        sim_id_i,
    input  logic               init_i,
    input  logic               eos_i,
    output logic [1:0]         status_o,
    output logic [63:0]        time_o,
    input  logic               put_req_i,
    input  logic [ID_W-1:0]    put_dst_i,
    input  logic [SIG_W-1:0]   put_sig_i,
    input  logic               put_type_i,
    input  logic [DATA_W-1:0]  put_data_bit_i,
    input  logic [DATA_W-1:0]  put_data_logic_i,
    output logic               put_ack_o,
    output logic               put_status_o,
    output logic               put_err_o,
    input  logic               get_req_i,
    input  logic [ID_W-1:0]    get_src_i,
    input  logic [SIG_W-1:0]   get_sig_i,
    output logic               get_done_o,
    output logic [DATA_W-1:0]  get_data_bit_o,
    output logic [DATA_W-1:0]  get_data_logic_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    output logic [FRAME_W-1:0] tx_frame_o,
    input  logic               rx_valid_i,
    output logic               rx_ready_o,
    input  logic [FRAME_W-1:0] rx_frame_i,
    output logic               overrun_o
);

    status_e     status_q, status_d;
    logic        hello_pend_q, hello_pend_d;
    logic        eos_pend_q, eos_pend_d;
    logic        tx_full_q, tx_full_d;
    frame_t      tx_frame_q, tx_frame_d;
    logic [63:0] time_q, time_d;
    logic        get_done_q, get_done_d;
    data_in_t    get_data_q, get_data_d;

    frame_t      rx_f;
    logic        ack_hit, mb_wr, mb_rd, mb_hit;
    data_in_t    mb_data;
    logic        unused_rx_typ;

    assign rx_f          = frame_t'(rx_frame_i);
    assign unused_rx_typ = rx_f.typ;
    assign rx_ready_o    = 1'b1;
    assign ack_hit       = rx_valid_i && (rx_f.kind == KIND_HELLO_ACK)
                           && (rx_f.data.data_bit[31:0] == sim_id_i);
    assign mb_wr         = rx_valid_i && (rx_f.kind == KIND_DATA) && (rx_f.dst == my_id_i);
    assign mb_rd         = get_req_i && (status_q == ST_ACTIVE);

    assign status_o         = status_q;
    assign time_o           = time_q;
    assign tx_valid_o       = tx_full_q;
    assign put_status_o     = tx_full_q;
    assign tx_frame_o       = tx_frame_q;
    assign get_done_o       = get_done_q;
    assign get_data_bit_o   = get_data_q.data_bit;
    assign get_data_logic_o = get_data_q.data_logic;

    shunt_fringe_mailbox u_mailbox (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (mb_wr),
        .wr_src_i  (rx_f.src),
        .wr_sig_i  (rx_f.sig),
        .wr_data_i (rx_f.data),
        .rd_en_i   (mb_rd),
        .rd_src_i  (get_src_i),
        .rd_sig_i  (get_sig_i),
        .rd_hit_o  (mb_hit),
        .rd_data_o (mb_data),
        .overrun_o (overrun_o)
    );

    // Status FSM and tx slot arbitration: HELLO, then EOS, then a waiting put.
    always_comb begin
        status_d     = status_q;
        hello_pend_d = hello_pend_q;
        eos_pend_d   = eos_pend_q;
        tx_full_d    = tx_full_q;
        tx_frame_d   = tx_frame_q;
        put_ack_o    = 1'b0;
        put_err_o    = put_req_i && (status_q != ST_ACTIVE);

        case (status_q)
            ST_INACTIVE: begin
                if (init_i) begin
                    status_d     = ST_PNP;
                    hello_pend_d = 1'b1;
                end
            end
            ST_PNP, ST_ACTIVE: begin
                if (eos_i) begin
                    status_d   = ST_EOS;
                    eos_pend_d = 1'b1;
                end else if ((status_q == ST_PNP) && ack_hit) begin
                    status_d = ST_ACTIVE;
                end
            end
            default: ;
        endcase

        if (tx_full_q && tx_ready_i) begin
            tx_full_d = 1'b0;
        end

        if (!tx_full_q) begin
            if (hello_pend_q) begin
                hello_pend_d = 1'b0;
                tx_full_d    = 1'b1;
                tx_frame_d   = make_frame(KIND_HELLO, my_id_i, '0, '0, 1'b0,
                                          data_in_t'{{32'd0, sim_id_i}, '0});
            end else if (eos_pend_q) begin
                eos_pend_d = 1'b0;
                tx_full_d  = 1'b1;
                tx_frame_d = make_frame(KIND_EOS, my_id_i, '0, '0, 1'b0, '0);
            end else if (put_req_i && (status_q == ST_ACTIVE)) begin
                put_ack_o  = 1'b1;
                tx_full_d  = 1'b1;
                tx_frame_d = make_frame(KIND_DATA, my_id_i, put_dst_i, put_sig_i, put_type_i,
                                        data_in_t'{put_data_bit_i, put_data_logic_i});
            end
        end
    end

    // Time counter and get result staging.
    always_comb begin
        time_d     = time_q + 64'd1;
        get_done_d = mb_rd && mb_hit;
        get_data_d = get_data_q;
        if (get_done_d) begin
            get_data_d = mb_data;
        end
    end

    // Endpoint state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            status_q     <= ST_INACTIVE;
            hello_pend_q <= 1'b0;
            eos_pend_q   <= 1'b0;
            tx_full_q    <= 1'b0;
            tx_frame_q   <= '0;
            time_q       <= '0;
            get_done_q   <= 1'b0;
            get_data_q   <= '0;
        end else begin
            status_q     <= status_d;
            hello_pend_q <= hello_pend_d;
            eos_pend_q   <= eos_pend_d;
            tx_full_q    <= tx_full_d;
            tx_frame_q   <= tx_frame_d;
            time_q       <= time_d;
            get_done_q   <= get_done_d;
            get_data_q   <= get_data_d;
        end
    end

endmodule

// File: tb/tb_shunt_fringe.sv
`timescale 1ns/1ps
// Directed bench for shunt_fringe with a tx-frame and get-data scoreboard.
module tb_shunt_fringe;

    localparam int ID_W    = 2;
    localparam int SIG_W   = 4;
    localparam int DATA_W  = 64;
    localparam int FRAME_W = 2 + 2*ID_W + SIG_W + 1 + 2*DATA_W;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [ID_W-1:0]    my_id_i;
    logic [31:0]        sim_id_i;
    logic               init_i, eos_i;
    logic [1:0]         status_o;
    logic [63:0]        time_o;
    logic               put_req_i;
    logic [ID_W-1:0]    put_dst_i;
    logic [SIG_W-1:0]   put_sig_i;
    logic               put_type_i;
    logic [DATA_W-1:0]  put_data_bit_i, put_data_logic_i;
    logic               put_ack_o, put_status_o, put_err_o;
    logic               get_req_i;
    logic [ID_W-1:0]    get_src_i;
    logic [SIG_W-1:0]   get_sig_i;
    logic               get_done_o;
    logic [DATA_W-1:0]  get_data_bit_o, get_data_logic_o;
    logic               tx_valid_o, tx_ready_i;
    logic [FRAME_W-1:0] tx_frame_o;
    logic               rx_valid_i, rx_ready_o;
    logic [FRAME_W-1:0] rx_frame_i;
    logic               overrun_o;

    int checks = 0;
    int errors = 0;

    logic [FRAME_W-1:0]  tx_q[$];
    logic [2*DATA_W-1:0] get_q[$];

    always #5 clk_i = ~clk_i;

    shunt_fringe #(.N_SRCDST(4), .N_SIG(16), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .my_id_i(my_id_i), .sim_id_i(sim_id_i),
        .init_i(init_i), .eos_i(eos_i), .status_o(status_o), .time_o(time_o),
        .put_req_i(put_req_i), .put_dst_i(put_dst_i), .put_sig_i(put_sig_i),
        .put_type_i(put_type_i), .put_data_bit_i(put_data_bit_i),
        .put_data_logic_i(put_data_logic_i), .put_ack_o(put_ack_o),
        .put_status_o(put_status_o), .put_err_o(put_err_o),
        .get_req_i(get_req_i), .get_src_i(get_src_i), .get_sig_i(get_sig_i),
        .get_done_o(get_done_o), .get_data_bit_o(get_data_bit_o),
        .get_data_logic_o(get_data_logic_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_frame_o(tx_frame_o),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_frame_i(rx_frame_i),
        .overrun_o(overrun_o)
    );

    // Frame builder in wire order: kind, src, dst, sig, type, data_bit, data_logic.
    function automatic logic [FRAME_W-1:0] mk(input logic [1:0] k, input logic [1:0] s,
                                              input logic [1:0] d, input logic [3:0] g,
                                              input logic t, input logic [63:0] b,
                                              input logic [63:0] l);
        return {k, s, d, g, t, b, l};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rx_send(input logic [FRAME_W-1:0] f);
        rx_valid_i = 1'b1;
        rx_frame_i = f;
        tick();
        rx_valid_i = 1'b0;
        rx_frame_i = '0;
    endtask

    // Waits (bounded) for a tx handshake and compares against the scoreboard head.
    task automatic expect_tx(input string tag);
        bit seen = 1'b0;
        logic [FRAME_W-1:0] exp;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk_i);
            if (tx_valid_o && tx_ready_i) begin
                seen = 1'b1;
                exp = (tx_q.size() != 0) ? tx_q.pop_front() : '0;
                check(tag, 256'(tx_frame_o), 256'(exp));
            end
            tick();
        end
        check({tag, "_seen"}, 256'(seen), 256'(1));
    endtask

    task automatic do_get(input logic [1:0] src, input logic [3:0] sig, input bit hit,
                          input logic [127:0] exp_data, input string tag);
        get_req_i = 1'b1;
        get_src_i = src;
        get_sig_i = sig;
        if (hit) get_q.push_back(exp_data);
        tick();
        get_req_i = 1'b0;
        check({tag, "_done"}, 256'(get_done_o), 256'(hit));
        if (hit && get_q.size() != 0)
            check({tag, "_data"}, 256'({get_data_bit_o, get_data_logic_o}), 256'(get_q.pop_front()));
    endtask

    task automatic do_put(input logic [1:0] d, input logic [3:0] g, input logic t,
                          input logic [63:0] b, input logic [63:0] l);
        put_req_i = 1'b1;
        put_dst_i = d;
        put_sig_i = g;
        put_type_i = t;
        put_data_bit_i = b;
        put_data_logic_i = l;
    endtask

    task automatic do_register(input string tag);
        init_i = 1'b1;
        tx_q.push_back(mk(2'd1, 2'd1, 2'd0, 4'd0, 1'b0, 64'h1234, 64'd0));
        tick();
        init_i = 1'b0;
        check({tag, "_pnp"}, 256'(status_o), 256'(1));
        expect_tx({tag, "_hello"});
        rx_valid_i = 1'b1;
        rx_frame_i = mk(2'd2, 2'd0, 2'd1, 4'd0, 1'b0, 64'h1234, 64'd0);
        @(negedge clk_i);
        check({tag, "_ack_pre"}, 256'(status_o), 256'(1));
        tick();
        rx_valid_i = 1'b0;
        rx_frame_i = '0;
        check({tag, "_active"}, 256'(status_o), 256'(2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        rst_ni = 1'b0; my_id_i = 2'd1; sim_id_i = 32'h1234;
        init_i = 1'b0; eos_i = 1'b0; put_req_i = 1'b0; put_dst_i = '0; put_sig_i = '0;
        put_type_i = 1'b0; put_data_bit_i = '0; put_data_logic_i = '0;
        get_req_i = 1'b0; get_src_i = '0; get_sig_i = '0;
        tx_ready_i = 1'b1; rx_valid_i = 1'b0; rx_frame_i = '0;

        // Reset state.
        repeat (3) tick();
        check("rst_status", 256'(status_o), 256'(0));
        check("rst_time", 256'(time_o), 256'(0));
        check("rst_tx_valid", 256'(tx_valid_o), 256'(0));
        check("rst_get_done", 256'(get_done_o), 256'(0));
        check("rst_get_data", 256'({get_data_bit_o, get_data_logic_o}), 256'(0));
        check("rst_overrun", 256'(overrun_o), 256'(0));
        check("rx_ready", 256'(rx_ready_o), 256'(1));
        rst_ni = 1'b1;
        repeat (5) tick();
        check("time_count", 256'(time_o), 256'(5));

        // Put while INACTIVE is an error, not an accept.
        do_put(2'd2, 4'd3, 1'b0, 64'hA5, 64'd0);
        @(negedge clk_i);
        check("put_err_inactive", 256'(put_err_o), 256'(1));
        check("put_ack_inactive", 256'(put_ack_o), 256'(0));
        tick();
        put_req_i = 1'b0;

        // Registration, with a wrong-id ACK first.
        init_i = 1'b1;
        tx_q.push_back(mk(2'd1, 2'd1, 2'd0, 4'd0, 1'b0, 64'h1234, 64'd0));
        tick();
        init_i = 1'b0;
        check("reg_pnp", 256'(status_o), 256'(1));
        expect_tx("reg_hello");
        rx_send(mk(2'd2, 2'd0, 2'd1, 4'd0, 1'b0, 64'h9999, 64'd0));
        tick();
        check("reg_bad_ack", 256'(status_o), 256'(1));
        rx_valid_i = 1'b1;
        rx_frame_i = mk(2'd2, 2'd0, 2'd1, 4'd0, 1'b0, 64'h1234, 64'd0);
        @(negedge clk_i);
        check("reg_ack_pre", 256'(status_o), 256'(1));
        tick();
        rx_valid_i = 1'b0;
        rx_frame_i = '0;
        check("reg_active", 256'(status_o), 256'(2));

        // Put with back-pressure: slot held for 4 cycles.
        tx_ready_i = 1'b0;
        do_put(2'd2, 4'd3, 1'b0, 64'hA5, 64'd0);
        @(negedge clk_i);
        check("put1_ack", 256'(put_ack_o), 256'(1));
        tx_q.push_back(mk(2'd0, 2'd1, 2'd2, 4'd3, 1'b0, 64'hA5, 64'd0));
        tick();
        put_req_i = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_ready_i = (i >= 3);
            @(negedge clk_i);
            if (put_status_o) n++;
            if (tx_valid_o && tx_ready_i && tx_q.size() != 0) begin
                seen = 1'b1;
                check("put1_frame", 256'(tx_frame_o), 256'(tx_q.pop_front()));
            end
            tick();
        end
        check("put1_status_cycles", 256'(n), 256'(4));
        check("put1_seen", 256'(seen), 256'(1));

        // A second put waits for the first to drain.
        tx_ready_i = 1'b0;
        do_put(2'd0, 4'd0, 1'b1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk_i);
        check("put2a_ack", 256'(put_ack_o), 256'(1));
        tx_q.push_back(mk(2'd0, 2'd1, 2'd0, 4'd0, 1'b1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF));
        tick();
        do_put(2'd3, 4'd15, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);
        @(negedge clk_i);
        check("put2b_wait", 256'(put_ack_o), 256'(0));
        tick();
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        check("put2b_wait_drain", 256'(put_ack_o), 256'(0));
        check("put2a_valid", 256'(tx_valid_o), 256'(1));
        check("put2a_frame", 256'(tx_frame_o), 256'(tx_q.pop_front()));
        tick();
        @(negedge clk_i);
        check("put2b_ack", 256'(put_ack_o), 256'(1));
        tx_q.push_back(mk(2'd0, 2'd1, 2'd3, 4'd15, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0));
        tick();
        put_req_i = 1'b0;
        expect_tx("put2b_frame");

        // Get miss, hit, repeat miss; frames for another dst are dropped.
        do_get(2'd2, 4'd1, 1'b0, '0, "get_empty");
        rx_send(mk(2'd0, 2'd2, 2'd1, 4'd1, 1'b0, 64'h55, 64'h5A));
        do_get(2'd2, 4'd1, 1'b1, {64'h55, 64'h5A}, "get_hit");
        do_get(2'd2, 4'd1, 1'b0, '0, "get_repeat");
        check("get_data_held", 256'({get_data_bit_o, get_data_logic_o}), 256'({64'h55, 64'h5A}));
        rx_send(mk(2'd0, 2'd2, 2'd3, 4'd1, 1'b0, 64'h66, 64'd0));
        do_get(2'd2, 4'd1, 1'b0, '0, "get_other_dst");

        // Same-cycle get and rx write to one entry.
        rx_send(mk(2'd0, 2'd3, 2'd1, 4'd0, 1'b0, 64'hAAA, 64'd0));
        rx_valid_i = 1'b1;
        rx_frame_i = mk(2'd0, 2'd3, 2'd1, 4'd0, 1'b1, 64'hBBB, 64'h1);
        do_get(2'd3, 4'd0, 1'b1, {64'hAAA, 64'd0}, "same_old");
        rx_valid_i = 1'b0;
        rx_frame_i = '0;
        check("same_no_overrun", 256'(overrun_o), 256'(0));
        do_get(2'd3, 4'd0, 1'b1, {64'hBBB, 64'h1}, "same_new");

        // Overrun: two writes without a get.
        rx_send(mk(2'd0, 2'd0, 2'd1, 4'd15, 1'b0, 64'h111, 64'd0));
        check("ovr_first", 256'(overrun_o), 256'(0));
        rx_send(mk(2'd0, 2'd0, 2'd1, 4'd15, 1'b0, 64'h222, 64'd0));
        check("ovr_set", 256'(overrun_o), 256'(1));
        do_get(2'd0, 4'd15, 1'b1, {64'h222, 64'd0}, "ovr_get");

        // Leave an entry filled, then EOS.
        rx_send(mk(2'd0, 2'd0, 2'd1, 4'd5, 1'b0, 64'h77, 64'd0));
        eos_i = 1'b1;
        tx_q.push_back(mk(2'd3, 2'd1, 2'd0, 4'd0, 1'b0, 64'd0, 64'd0));
        tick();
        eos_i = 1'b0;
        check("eos_status", 256'(status_o), 256'(3));
        expect_tx("eos_frame");
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (tx_valid_o) n++;
            tick();
        end
        check("eos_single", 256'(n), 256'(0));
        do_put(2'd2, 4'd3, 1'b0, 64'h1, 64'd0);
        @(negedge clk_i);
        check("eos_put_err", 256'(put_err_o), 256'(1));
        tick();
        put_req_i = 1'b0;

        // Mid-operation reset clears status, time, overrun and mailbox.
        rst_ni = 1'b0;
        repeat (2) tick();
        check("rst2_status", 256'(status_o), 256'(0));
        check("rst2_time", 256'(time_o), 256'(0));
        check("rst2_overrun", 256'(overrun_o), 256'(0));
        check("rst2_get_data", 256'({get_data_bit_o, get_data_logic_o}), 256'(0));
        rst_ni = 1'b1;
        repeat (3) tick();
        check("rst2_time_count", 256'(time_o), 256'(3));
        do_register("rereg");
        do_get(2'd0, 4'd5, 1'b0, '0, "rst2_mailbox");

        check("sb_tx_empty", 256'(tx_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
